// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT schedule reader: modulus, ROM entry layout,
// butterfly command type and sequencer state encoding.
package ntt_pkg;

    localparam int unsigned Q          = 3329;

    // A 64-bit ROM entry holds two 32-bit halves; bf0 is the upper half.
    localparam int unsigned ENTRY_W    = 64;
    localparam int unsigned HALF_W     = 32;
    localparam int unsigned BF0_LSB    = 32;
    localparam int unsigned BF1_LSB    = 0;

    // Field positions inside one 32-bit half.
    localparam int unsigned RSV_LSB    = 28;
    localparam int unsigned RSV_W      = 4;
    localparam int unsigned ZETA_LSB   = 16;
    localparam int unsigned ZETA_W     = 12;
    localparam int unsigned A_LSB      = 8;
    localparam int unsigned B_LSB      = 0;
    localparam int unsigned IDX_W      = 8;

    // Command FIFO sizing shared by the reader and its debug port.
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_CNT_W = 3;

    typedef struct packed {
        logic [ZETA_W-1:0] zeta;
        logic [IDX_W-1:0]  a;
        logic [IDX_W-1:0]  b;
    } bf_cmd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic bf_cmd_t unpack_half(input logic [HALF_W-1:0] half);
        bf_cmd_t c;
        c.zeta = half[ZETA_LSB +: ZETA_W];
        c.a    = half[A_LSB +: IDX_W];
        c.b    = half[B_LSB +: IDX_W];
        return c;
    endfunction

    function automatic logic rsv_set(input logic [HALF_W-1:0] half);
        return half[RSV_LSB +: RSV_W] != '0;
    endfunction

endpackage

// File: rtl/ntt_sched_reader_if.sv
// Butterfly command bus between the schedule reader and the datapath.
// Handshake: the master holds bf_valid and all bf* fields stable until the
// slave samples bf_ready high on a rising edge with bf_valid high; that edge
// transfers exactly one command pair. bf_valid never depends on bf_ready.
interface ntt_sched_reader_if;
    import ntt_pkg::*;

    logic              bf_valid;
    logic              bf_ready;
    logic [ZETA_W-1:0] bf0_zeta;
    logic [IDX_W-1:0]  bf0_a;
    logic [IDX_W-1:0]  bf0_b;
    logic [ZETA_W-1:0] bf1_zeta;
    logic [IDX_W-1:0]  bf1_a;
    logic [IDX_W-1:0]  bf1_b;

    modport master (
        output bf_valid, bf0_zeta, bf0_a, bf0_b, bf1_zeta, bf1_a, bf1_b,
        input  bf_ready
    );

    modport slave (
        input  bf_valid, bf0_zeta, bf0_a, bf0_b, bf1_zeta, bf1_a, bf1_b,
        output bf_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head, occupancy count and a
// synchronous flush. Storage is cleared by reset so the head reads zero.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; flush discards contents but keeps data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ntt_sched_reader.sv
// Walks the NTT schedule ROM on start, buffers entries in a small FIFO and
// presents each entry as a pair of butterfly commands with backpressure.
module ntt_sched_reader
    import ntt_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 128,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned Q           = ntt_pkg::Q
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [ENTRY_W-1:0]    rom_dout,
    ntt_sched_reader_if.master    bf,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output state_t                dbg_state,
    output logic [FIFO_CNT_W-1:0] dbg_fifo_count
);

    state_t                state;
    state_t                state_nx;
    logic [1:0]            rd_pend;      // [0]: address register valid, [1]: rom_dout valid
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_head;
    logic [FIFO_CNT_W-1:0] inflight;
    logic [FIFO_CNT_W-1:0] credit_sum;
    logic                  can_issue;
    logic                  start_ok;
    logic                  at_last;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  drain_empty;
    logic                  entry_bad;
    bf_cmd_t               in_cmd0;
    bf_cmd_t               in_cmd1;
    bf_cmd_t               out_cmd0;
    bf_cmd_t               out_cmd1;

    // Reads in flight plus buffered entries may never exceed the FIFO depth,
    // which makes overflow impossible without looking at bf_ready.
    assign inflight   = FIFO_CNT_W'(rd_pend[0]) + FIFO_CNT_W'(rd_pend[1]);
    assign credit_sum = fifo_count + inflight;
    assign can_issue  = credit_sum < FIFO_CNT_W'(FIFO_DEPTH);

    assign start_ok = start && !abort && (state == S_IDLE);
    assign at_last  = (rom_addr == ADDR_W'(NUM_ENTRIES - 1));
    assign issue    = (state == S_RUN) && !at_last && can_issue && !abort;
    assign push     = rd_pend[1];
    assign pop      = bf.bf_valid && bf.bf_ready;

    // Drain finishes on the cycle the last buffered pair is taken, so done
    // follows the final acceptance directly.
    assign drain_empty = (rd_pend == 2'b00) &&
                         ((fifo_count == '0) || ((fifo_count == FIFO_CNT_W'(1)) && pop));

    assign in_cmd0   = unpack_half(rom_dout[BF0_LSB +: HALF_W]);
    assign in_cmd1   = unpack_half(rom_dout[BF1_LSB +: HALF_W]);
    assign entry_bad = rsv_set(rom_dout[BF0_LSB +: HALF_W]) ||
                       rsv_set(rom_dout[BF1_LSB +: HALF_W]) ||
                       (32'(in_cmd0.zeta) >= Q) ||
                       (32'(in_cmd1.zeta) >= Q);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (FIFO_CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (abort),
        .push  (push),
        .din   (rom_dout),
        .pop   (pop),
        .dout  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign out_cmd0    = unpack_half(fifo_head[BF0_LSB +: HALF_W]);
    assign out_cmd1    = unpack_half(fifo_head[BF1_LSB +: HALF_W]);
    assign bf.bf_valid = !fifo_empty;
    assign bf.bf0_zeta = out_cmd0.zeta;
    assign bf.bf0_a    = out_cmd0.a;
    assign bf.bf0_b    = out_cmd0.b;
    assign bf.bf1_zeta = out_cmd1.zeta;
    assign bf.bf1_a    = out_cmd1.a;
    assign bf.bf1_b    = out_cmd1.b;

    assign dbg_state      = state;
    assign dbg_fifo_count = fifo_count;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic; abort overrides every transition.
    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nx = S_RUN;
                S_RUN:   if (at_last) state_nx = S_DRAIN;
                S_DRAIN: if (drain_empty) state_nx = S_DONE;
                S_DONE:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // Address counter and read-tracking pipe; a run always begins at address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            rd_pend  <= 2'b00;
        end else if (abort) begin
            rom_addr <= '0;
            rd_pend  <= 2'b00;
        end else begin
            rd_pend[1] <= rd_pend[0];
            if (start_ok) begin
                rom_addr   <= '0;
                rd_pend[0] <= 1'b1;
            end else if (issue) begin
                rom_addr   <= rom_addr + ADDR_W'(1);
                rd_pend[0] <= 1'b1;
            end else begin
                rd_pend[0] <= 1'b0;
            end
        end
    end

    // Sticky malformed-entry flag, evaluated on each accepted ROM word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (start_ok) begin
            err <= 1'b0;
        end else if (push && !abort && entry_bad) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ntt_sched_reader.sv
// Bench for ntt_sched_reader: table of single-entry vectors applied over full
// runs, a scoreboard of expected command pairs, and hand-written sequences
// for backpressure, abort and asynchronous reset.
module tb_ntt_sched_reader;
    import ntt_pkg::*;

    localparam int unsigned N = 128;

    typedef struct {
        logic [63:0] entry;
        logic [11:0] z0;
        logic [7:0]  a0;
        logic [7:0]  b0;
        logic [11:0] z1;
        logic [7:0]  a1;
        logic [7:0]  b1;
        logic        exp_err;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [6:0]  rom_addr;
    logic [63:0] rom_dout = '0;
    logic        busy;
    logic        done;
    logic        err;
    state_t      dbg_state;
    logic [2:0]  dbg_fifo_count;

    ntt_sched_reader_if bfi ();

    ntt_sched_reader #(
        .NUM_ENTRIES (N),
        .ADDR_W      (7),
        .Q           (3329)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .rom_addr       (rom_addr),
        .rom_dout       (rom_dout),
        .bf             (bfi),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .dbg_state      (dbg_state),
        .dbg_fifo_count (dbg_fifo_count)
    );

    always #5 clk = ~clk;

    // Registered ROM model, one cycle of read latency.
    logic [63:0] rom_mem [N];
    always @(posedge clk) rom_dout <= rom_mem[rom_addr];

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [55:0] exp_q[$];
    logic [63:0] base_rom [N];
    logic [55:0] base_exp [N];
    vec_t        vecs [8];
    logic [55:0] act_fields;
    logic [55:0] exp_v;
    logic        prev_hold   = 1'b0;
    logic [55:0] prev_fields = '0;

    assign act_fields = {bfi.bf0_zeta, bfi.bf0_a, bfi.bf0_b,
                         bfi.bf1_zeta, bfi.bf1_a, bfi.bf1_b};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: accepted pairs against the expected queue, stall stability,
    // and the FIFO occupancy bound.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_hold) begin
                check("hold_valid", 64'(bfi.bf_valid), 64'd1);
                check("hold_fields", 64'(act_fields), 64'(prev_fields));
            end
            n_checks++;
            assert (dbg_fifo_count <= 3'd4) else begin
                n_fail++;
                $display("FAIL fifo_bound: actual %0d required <= 4", dbg_fifo_count);
            end
            if (bfi.bf_valid && bfi.bf_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pair", 64'(act_fields), 64'd0 - 64'd1);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("pair", 64'(act_fields), 64'(exp_v));
                end
            end
            prev_hold   <= bfi.bf_valid && !bfi.bf_ready && !abort;
            prev_fields <= act_fields;
        end else begin
            prev_hold <= 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_base();
        for (int k = 0; k < int'(N); k++) rom_mem[k] = base_rom[k];
        for (int k = 0; k < int'(N); k++) exp_q.push_back(base_exp[k]);
    endtask

    // One full run with bf_ready high; rom entry 0 comes from the vector.
    task automatic run_vec(input vec_t v, input bit start_in_done);
        int cyc;
        int nvalid;
        bit seen;
        for (int k = 1; k < int'(N); k++) rom_mem[k] = base_rom[k];
        rom_mem[0] = v.entry;
        exp_q.push_back({v.z0, v.a0, v.b0, v.z1, v.a1, v.b1});
        for (int k = 1; k < int'(N); k++) exp_q.push_back(base_exp[k]);
        bfi.bf_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);                                        // cycle 1
        check("c1_busy", 64'(busy), 64'd1);
        check("c1_addr", 64'(rom_addr), 64'd0);
        check("c1_err_clear", 64'(err), 64'd0);
        check("c1_valid", 64'(bfi.bf_valid), 64'd0);
        step();
        @(negedge clk);                                        // cycle 2
        check("c2_addr", 64'(rom_addr), 64'd1);
        check("c2_valid", 64'(bfi.bf_valid), 64'd0);
        check("c2_err", 64'(err), 64'd0);
        step();
        @(negedge clk);                                        // cycle 3
        check("c3_valid", 64'(bfi.bf_valid), 64'd1);
        check("c3_bf0_zeta", 64'(bfi.bf0_zeta), 64'(v.z0));
        check("c3_bf0_a", 64'(bfi.bf0_a), 64'(v.a0));
        check("c3_bf0_b", 64'(bfi.bf0_b), 64'(v.b0));
        check("c3_bf1_zeta", 64'(bfi.bf1_zeta), 64'(v.z1));
        check("c3_bf1_a", 64'(bfi.bf1_a), 64'(v.a1));
        check("c3_bf1_b", 64'(bfi.bf1_b), 64'(v.b1));
        check("c3_err", 64'(err), 64'(v.exp_err));
        nvalid = 1;
        cyc    = 3;
        seen   = 1'b0;
        while (cyc < 400 && !seen) begin
            step();
            cyc++;
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (bfi.bf_valid) nvalid++;
            if (cyc == 130) begin
                check("c130_bf0_zeta", 64'(bfi.bf0_zeta), 64'd171);
                check("c130_bf0_a", 64'(bfi.bf0_a), 64'hef);
                check("c130_bf0_b", 64'(bfi.bf0_b), 64'hff);
                check("c130_bf1_zeta", 64'(bfi.bf1_zeta), 64'd1468);
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        check("done_cycle", 64'(cyc), 64'd131);
        check("valid_cycles", 64'(nvalid), 64'd128);
        if (start_in_done) start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);                                        // cycle 132
        check("end_busy", 64'(busy), 64'd0);
        check("end_done", 64'(done), 64'd0);
        check("end_err", 64'(err), 64'(v.exp_err));
        check("end_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_random();
        int cyc;
        bit seen;
        load_base();
        bfi.bf_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        while (cyc < 3000 && !seen) begin
            bfi.bf_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done) seen = 1'b1;
            step();
            cyc++;
        end
        bfi.bf_ready = 1'b1;
        check("rnd_done_seen", 64'(seen), 64'd1);
        check("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check("rnd_busy", 64'(busy), 64'd0);
        check("rnd_err", 64'(err), 64'd0);
    endtask

    task automatic run_abort();
        load_base();
        bfi.bf_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;                                          // cycle 1
        repeat (39) step();                                    // cycle 40
        abort = 1'b1;
        step();
        abort = 1'b0;
        exp_q.delete();
        @(negedge clk);                                        // cycle 41
        check("ab_valid", 64'(bfi.bf_valid), 64'd0);
        check("ab_busy", 64'(busy), 64'd0);
        check("ab_state", 64'(dbg_state), 64'(S_IDLE));
        check("ab_addr", 64'(rom_addr), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            check("ab_no_done", 64'(done), 64'd0);
            check("ab_stay_empty", 64'(bfi.bf_valid), 64'd0);
        end
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("start_abort_busy", 64'(busy), 64'd0);
        check("start_abort_valid", 64'(bfi.bf_valid), 64'd0);
    endtask

    task automatic run_reset();
        load_base();
        bfi.bf_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;                                          // cycle 1
        repeat (19) step();                                    // cycle 20
        start = 1'b1;
        step();
        start = 1'b0;                                          // cycle 21
        @(negedge clk);
        check("restart_ignored_addr", 64'(rom_addr), 64'd20);
        check("restart_ignored_state", 64'(dbg_state), 64'(S_RUN));
        repeat (39) step();                                    // cycle 60
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("ar_valid", 64'(bfi.bf_valid), 64'd0);
        check("ar_fields", 64'(act_fields), 64'd0);
        check("ar_addr", 64'(rom_addr), 64'd0);
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_done", 64'(done), 64'd0);
        check("ar_err", 64'(err), 64'd0);
        check("ar_state", 64'(dbg_state), 64'(S_IDLE));
        step();
        rst_n = 1'b1;                                          // cycle 61
        step();
        @(negedge clk);                                        // cycle 62
        check("ar_no_capture_valid", 64'(bfi.bf_valid), 64'd0);
        check("ar_no_capture_count", 64'(dbg_fifo_count), 64'd0);
        check("ar_idle_busy", 64'(busy), 64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [11:0] z0;
        logic [11:0] z1;
        logic [7:0]  a0;
        logic [7:0]  b0;
        logic [7:0]  a1;
        logic [7:0]  b1;

        for (int k = 0; k < int'(N); k++) begin
            z0 = 12'((k * 97 + 3) % 3329);
            a0 = 8'(k);
            b0 = 8'(255 - k);
            z1 = 12'((k * 211 + 7) % 3329);
            a1 = 8'(k) ^ 8'h5a;
            b1 = 8'(k + 1);
            if (k == 0) begin
                z0 = 12'd1861; a0 = 8'h00; b0 = 8'h10;
                z1 = 12'd3158; a1 = 8'h00; b1 = 8'h10;
            end
            if (k == 127) begin
                z0 = 12'd171;  a0 = 8'hef; b0 = 8'hff;
                z1 = 12'd1468; a1 = 8'h7f; b1 = 8'h80;
            end
            base_rom[k] = {4'h0, z0, a0, b0, 4'h0, z1, a1, b1};
            base_exp[k] = {z0, a0, b0, z1, a1, b1};
            rom_mem[k]  = base_rom[k];
        end

        vecs[0] = '{64'h0745_0010_0c56_0010, 12'd1861, 8'h00, 8'h10, 12'd3158, 8'h00, 8'h10, 1'b0};
        vecs[1] = '{64'h00ab_efff_05bc_1234, 12'd171,  8'hef, 8'hff, 12'd1468, 8'h12, 8'h34, 1'b0};
        vecs[2] = '{64'h0d01_0000_0000_0000, 12'd3329, 8'h00, 8'h00, 12'd0,    8'h00, 8'h00, 1'b1};
        vecs[3] = '{64'h0d00_0102_0d00_0304, 12'd3328, 8'h01, 8'h02, 12'd3328, 8'h03, 8'h04, 1'b0};
        vecs[4] = '{64'h8000_0001_0000_0002, 12'd0,    8'h00, 8'h01, 12'd0,    8'h00, 8'h02, 1'b1};
        vecs[5] = '{64'h0000_0000_1123_4567, 12'd0,    8'h00, 8'h00, 12'd291,  8'h45, 8'h67, 1'b1};
        vecs[6] = '{64'h0001_0203_0d01_0405, 12'd1,    8'h02, 8'h03, 12'd3329, 8'h04, 8'h05, 1'b1};
        vecs[7] = '{64'h0fff_ffff_0000_0000, 12'd4095, 8'hff, 8'hff, 12'd0,    8'h00, 8'h00, 1'b1};

        bfi.bf_ready = 1'b0;
        #1;
        check("rst_addr", 64'(rom_addr), 64'd0);
        check("rst_valid", 64'(bfi.bf_valid), 64'd0);
        check("rst_fields", 64'(act_fields), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(S_IDLE));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], (i == 7));
        end

        run_random();

        run_abort();
        run_vec(vecs[0], 1'b0);

        run_reset();
        run_vec(vecs[1], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so a stuck design still ends the run.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
